// File: rtl/lcd_bus_pkg.sv
// Shared constants for the LCD bus PIO: register map, STATUS bit positions
// and the transfer FSM state encoding.
package lcd_bus_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_PULSE  = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;

    localparam int STAT_EMPTY = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_BUSY  = 2;
    localparam int STAT_OVF   = 3;
    localparam int STAT_LEVEL = 8;

    localparam int CTRL_FLUSH = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_PULSE = 2'd2,
        ST_HOLD  = 2'd3
    } lcd_state_e;

endpackage

// File: rtl/lcd_bus_fifo.sv
// Synchronous FIFO buffering host words for the LCD bus sequencer.
// Ports: clk, reset, push/wdata, pop/rdata (show-ahead), flush, full, empty, level.
module lcd_bus_fifo #(
    parameter int WIDTH = 15,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Flush dominates both push and pop in the same cycle.
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    // Extra pointer MSB distinguishes full from empty on wrap.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = wr_ptr - rd_ptr;
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/lcd_bus_pio.sv
// Avalon-MM LCD bus port: FIFO-buffered words replayed with setup/strobe/hold.
// Ports: clk, reset, address/chipselect/write_n/writedata/readdata, out_port, out_strobe.
module lcd_bus_pio
    import lcd_bus_pkg::*;
#(
    parameter int WIDTH         = 15,
    parameter int DEPTH         = 4,
    parameter int SETUP_CYCLES  = 2,
    parameter int HOLD_CYCLES   = 2,
    parameter int PULSE_BITS    = 8,
    parameter int PULSE_DEFAULT = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [WIDTH-1:0]  out_port,
    output logic              out_strobe
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = 32;

    logic                  wr;
    logic                  push;
    logic                  pop;
    logic                  flush;
    logic [WIDTH-1:0]      fifo_rdata;
    logic                  full;
    logic                  empty;
    logic [AW:0]           level;
    lcd_state_e            state;
    logic [CW-1:0]         cnt;
    logic                  cnt_zero;
    logic [PULSE_BITS-1:0] pulse_len;
    logic [PULSE_BITS-1:0] pulse_lat;
    logic                  ovf;
    logic                  wdata_unused;

    assign wr       = chipselect && !write_n;
    assign push     = wr && (address == ADDR_DATA);
    assign flush    = wr && (address == ADDR_CTRL) && writedata[CTRL_FLUSH];
    assign pop      = (state == ST_IDLE) && !empty;
    assign cnt_zero = (cnt == '0);

    assign wdata_unused = ^writedata;

    lcd_bus_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (writedata[WIDTH-1:0]),
        .pop   (pop),
        .flush (flush),
        .rdata (fifo_rdata),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    // Pulse length is latched at word start so mid-transfer
    // register writes only affect the following word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            out_port   <= '0;
            out_strobe <= 1'b0;
            pulse_lat  <= PULSE_BITS'(PULSE_DEFAULT);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!empty) begin
                        out_port  <= fifo_rdata;
                        cnt       <= CW'(SETUP_CYCLES - 1);
                        pulse_lat <= pulse_len;
                        state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt_zero) begin
                        out_strobe <= 1'b1;
                        cnt        <= CW'(pulse_lat) - 1'b1;
                        state      <= ST_PULSE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (cnt_zero) begin
                        out_strobe <= 1'b0;
                        cnt        <= CW'(HOLD_CYCLES - 1);
                        state      <= ST_HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    if (cnt_zero) state <= ST_IDLE;
                    else          cnt   <= cnt - 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pulse_len <= PULSE_BITS'(PULSE_DEFAULT);
            ovf       <= 1'b0;
        end else begin
            if (wr && (address == ADDR_PULSE)) begin
                // Zero would stall the counter; clamp to one cycle.
                if (writedata[PULSE_BITS-1:0] == '0)
                    pulse_len <= PULSE_BITS'(1);
                else
                    pulse_len <= writedata[PULSE_BITS-1:0];
            end
            // Full is sampled before any same-cycle pop.
            if (push && full && !flush)
                ovf <= 1'b1;
            else if (wr && (address == ADDR_STATUS) && writedata[STAT_OVF])
                ovf <= 1'b0;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:   readdata = 32'(out_port);
            ADDR_STATUS: begin
                readdata[STAT_EMPTY]         = empty;
                readdata[STAT_FULL]          = full;
                readdata[STAT_BUSY]          = (state != ST_IDLE);
                readdata[STAT_OVF]           = ovf;
                readdata[STAT_LEVEL +: AW+1] = level;
            end
            ADDR_PULSE:  readdata = 32'(pulse_len);
            default:     readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_lcd_bus_pio.sv
// Randomised self-checking bench for lcd_bus_pio against a timestamp model.
// Ports: none; drives the DUT bus and checks out_port/out_strobe/readdata.
module tb_lcd_bus_pio;
    import lcd_bus_pkg::*;

    localparam int W  = 15;
    localparam int D  = 4;
    localparam int S  = 2;
    localparam int H  = 2;
    localparam int PD = 12;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [1:0]   address = '0;
    logic         chipselect = 1'b0;
    logic         write_n = 1'b1;
    logic [31:0]  writedata = '0;
    logic [31:0]  readdata;
    logic [W-1:0] out_port;
    logic         out_strobe;

    always #5 clk = ~clk;

    lcd_bus_pio #(
        .WIDTH         (W),
        .DEPTH         (D),
        .SETUP_CYCLES  (S),
        .HOLD_CYCLES   (H),
        .PULSE_BITS    (8),
        .PULSE_DEFAULT (PD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .out_strobe (out_strobe)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Model: each word popped at edge t strobes over edges
    // [t+S, t+S+p) and frees the engine at t+S+p+H+1.
    int           cyc = 0;
    logic [W-1:0] mq[$];
    int           free_at = 0;
    int           cur_pop = -1;
    int           cur_p = 0;
    logic [W-1:0] cur_w = '0;
    logic         m_ovf = 1'b0;
    int           preg = PD;
    logic         m_wr;
    logic         m_full;

    function automatic logic m_strobe();
        return cur_pop >= 0 && cyc >= cur_pop + S && cyc < cur_pop + S + cur_p;
    endfunction

    function automatic logic m_busy();
        return cur_pop >= 0 && cyc < cur_pop + S + cur_p + H;
    endfunction

    function automatic logic [31:0] m_read(input logic [1:0] a);
        logic [31:0] r;
        r = '0;
        if (a == ADDR_DATA) r = 32'(cur_w);
        else if (a == ADDR_STATUS) begin
            r[0] = (mq.size() == 0);
            r[1] = (mq.size() == D);
            r[2] = m_busy();
            r[3] = m_ovf;
            r[15:8] = 8'(mq.size());
        end else if (a == ADDR_PULSE) r = 32'(preg);
        return r;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            free_at = 0;
            cur_pop = -1;
            cur_p   = 0;
            cur_w   = '0;
            m_ovf   = 1'b0;
            preg    = PD;
        end else begin
            cyc++;
            m_wr   = chipselect && !write_n;
            m_full = (mq.size() == D);
            if (mq.size() > 0 && cyc >= free_at) begin
                cur_w   = mq.pop_front();
                cur_pop = cyc;
                cur_p   = preg;
                free_at = cyc + S + cur_p + H + 1;
            end
            if (m_wr && address == ADDR_CTRL && writedata[0]) begin
                mq.delete();
            end else if (m_wr && address == ADDR_DATA) begin
                if (m_full) m_ovf = 1'b1;
                else        mq.push_back(writedata[W-1:0]);
            end
            if (m_wr && address == ADDR_STATUS && writedata[3])
                m_ovf = 1'b0;
            if (m_wr && address == ADDR_PULSE)
                preg = (writedata[7:0] == 8'd0) ? 1 : int'(writedata[7:0]);
        end
    end

    always @(negedge clk) begin
        check("port", 32'(out_port), 32'(cur_w));
        check("strobe", 32'(out_strobe), 32'(m_strobe()));
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_rd(input string tag, input logic [1:0] a);
        address = a;
        @(negedge clk);
        check(tag, readdata, m_read(a));
        @(posedge clk);
        #1;
    endtask

    task automatic wait_stb(input logic lvl, input string tag);
        int k;
        k = 0;
        while (out_strobe !== lvl && k < 300) begin
            tick(1);
            k++;
        end
        check(tag, 32'(out_strobe), 32'(lvl));
    endtask

    task automatic measure(input string tag, input int want);
        int w;
        wait_stb(1'b1, "stb_rise");
        w = 0;
        while (out_strobe === 1'b1 && w < 300) begin
            w++;
            tick(1);
        end
        check(tag, 32'(w), 32'(want));
    endtask

    initial begin
        int r;
        #12;
        check("rst_port", 32'(out_port), 32'h0);
        check("rst_stb", 32'(out_strobe), 32'h0);
        reset = 1'b0;
        tick(1);
        address = ADDR_STATUS;
        #1;
        check("rst_status", readdata, 32'h1);
        bus_rd("rst_status_m", ADDR_STATUS);
        bus_rd("rst_pulse", ADDR_PULSE);

        bus_wr(ADDR_DATA, 32'h1A5);
        bus_rd("level1", ADDR_STATUS);
        measure("width12", PD);
        check("word1a5", 32'(out_port), 32'h1A5);
        tick(H + 1);
        bus_rd("idle_after", ADDR_STATUS);

        for (int i = 0; i < 6; i++) bus_wr(ADDR_DATA, 32'h100 + 32'(i));
        bus_rd("ovf_set", ADDR_STATUS);
        bus_wr(ADDR_STATUS, 32'h8);
        bus_rd("ovf_clr", ADDR_STATUS);
        tick(110);
        bus_rd("drained", ADDR_STATUS);

        bus_wr(ADDR_PULSE, 32'h0);
        bus_rd("pulse0", ADDR_PULSE);
        bus_wr(ADDR_DATA, 32'h2AA);
        measure("width1", 1);
        tick(10);
        bus_wr(ADDR_PULSE, 32'd12);
        bus_wr(ADDR_DATA, 32'h011);
        bus_wr(ADDR_DATA, 32'h022);
        wait_stb(1'b1, "mid_hi");
        bus_wr(ADDR_PULSE, 32'd3);
        wait_stb(1'b0, "mid_lo");
        measure("width3", 3);
        tick(20);

        bus_wr(ADDR_PULSE, 32'd12);
        bus_wr(ADDR_DATA, 32'h031);
        bus_wr(ADDR_DATA, 32'h032);
        bus_wr(ADDR_DATA, 32'h033);
        bus_wr(ADDR_CTRL, 32'h1);
        bus_rd("flushed", ADDR_STATUS);
        bus_rd("ctrl_rd", ADDR_CTRL);
        tick(60);
        check("flush_last", 32'(out_port), 32'h031);

        bus_wr(ADDR_DATA, 32'h041);
        bus_wr(ADDR_DATA, 32'h042);
        bus_wr(ADDR_DATA, 32'h043);
        wait_stb(1'b1, "pre_rst");
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("arst_stb", 32'(out_strobe), 32'h0);
        check("arst_port", 32'(out_port), 32'h0);
        @(negedge clk);
        #1;
        reset = 1'b0;
        tick(1);
        bus_rd("post_rst", ADDR_STATUS);
        tick(40);
        check("no_stb", 32'(out_strobe), 32'h0);

        repeat (500) begin
            r = $urandom_range(0, 19);
            if (r < 7)
                bus_wr(ADDR_DATA, $urandom);
            else if (r < 9)
                bus_wr(ADDR_PULSE, 32'($urandom_range(0, 4)));
            else if (r == 9)
                bus_wr(ADDR_STATUS, $urandom);
            else if (r == 10)
                bus_wr(ADDR_CTRL, 32'($urandom_range(0, 3)));
            else if (r < 16)
                bus_rd("rand_rd", 2'($urandom_range(0, 3)));
            else
                tick(1);
        end
        tick(150);
        bus_rd("final", ADDR_STATUS);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
